// File: rtl/pac_seq.sv
// Phase-to-amplitude converter sequencer: ROM coefficient loader, phase accumulator and pipeline drain.
// Optional output-phase dithering is enabled by defining PAC_DITHER_EN.
module pac_seq #(
  parameter int PHASE_W    = 32,
  parameter int PIPE_DEPTH = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_ld_valid,
  input  logic [47:0]        i_ld_data,
  output logic               o_ld_ready,
  input  logic               i_run_en,
  input  logic [PHASE_W-1:0] i_fcw,
  output logic               o_cen,
  output logic               o_wen,
  output logic [5:0]         o_index_wri,
  output logic [47:0]        o_d,
  output logic [5:0]         o_index_rea,
  output logic [2:0]         o_index_qua,
  output logic [6:0]         o_index_cor,
  output logic               o_wen_in,
  output logic               o_loaded,
  output logic               o_busy
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [PHASE_W-1:0] r_acc;
  logic [5:0]         r_addr;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic               r_ld_ready;
  logic               r_cen;
  logic               r_wen;
  logic [5:0]         r_index_wri;
  logic [47:0]        r_d;
  logic [5:0]         r_index_rea;
  logic [2:0]         r_index_qua;
  logic [6:0]         r_index_cor;
  logic               r_wen_in;
  logic               r_loaded;
  logic               r_busy;

  logic               w_hs;
  logic               w_sample;
  logic               w_ld_ready;
  logic               w_busy;
  logic               w_wen;
  logic               w_cen;
  logic               w_wen_in;
  logic [15:0]        w_phase_hi;

`ifdef PAC_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_carry;

  // Only the carry out of the dithered low half can reach the 16 bits the converter consumes.
  assign w_carry    = r_acc[PHASE_W-17:PHASE_W-32] > ~r_lfsr;
  assign w_phase_hi = r_acc[PHASE_W-1:PHASE_W-16] + {15'd0, w_carry};
`else
  assign w_phase_hi = r_acc[PHASE_W-1:PHASE_W-16];
`endif

  assign w_hs     = (r_state == S_LOAD) && i_ld_valid;
  assign w_sample = (r_state == S_RUN) && i_run_en;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start)                   w_next_state = S_LOAD;
        else if (i_run_en && r_loaded) w_next_state = S_RUN;
      end
      S_LOAD:  if (w_hs && r_addr == 6'd63) w_next_state = S_IDLE;
      S_RUN:   if (!i_run_en) w_next_state = S_FLUSH;
      S_FLUSH: if (r_flush_cnt == CNT_W'(PIPE_DEPTH)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered control outputs.
  always_comb begin
    w_ld_ready = (w_next_state == S_LOAD);
    w_busy     = (w_next_state != S_IDLE);
    w_wen      = w_hs;
    w_cen      = w_hs || w_sample;
    w_wen_in   = w_sample;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc       <= '0;
      r_addr      <= '0;
      r_flush_cnt <= '0;
      r_ld_ready  <= 1'b0;
      r_cen       <= 1'b0;
      r_wen       <= 1'b0;
      r_index_wri <= '0;
      r_d         <= '0;
      r_index_rea <= '0;
      r_index_qua <= '0;
      r_index_cor <= '0;
      r_wen_in    <= 1'b0;
      r_loaded    <= 1'b0;
      r_busy      <= 1'b0;
`ifdef PAC_DITHER_EN
      r_lfsr      <= 16'hACE1;
`endif
    end else begin
      r_ld_ready <= w_ld_ready;
      r_busy     <= w_busy;
      r_wen      <= w_wen;
      r_cen      <= w_cen;
      r_wen_in   <= w_wen_in;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr   <= '0;
            r_loaded <= 1'b0;
          end else if (i_run_en && r_loaded) begin
            r_acc <= '0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_index_wri <= r_addr;
            r_d         <= i_ld_data;
            r_addr      <= r_addr + 6'd1;
            if (r_addr == 6'd63) r_loaded <= 1'b1;
          end
        end
        S_RUN: begin
          if (i_run_en) begin
            r_index_qua <= w_phase_hi[15:13];
            r_index_rea <= w_phase_hi[12:7];
            r_index_cor <= w_phase_hi[6:0];
            r_acc       <= r_acc + i_fcw;
`ifdef PAC_DITHER_EN
            r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
`endif
          end else begin
            r_flush_cnt <= '0;
          end
        end
        S_FLUSH: r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_ld_ready  = r_ld_ready;
  assign o_cen       = r_cen;
  assign o_wen       = r_wen;
  assign o_index_wri = r_index_wri;
  assign o_d         = r_d;
  assign o_index_rea = r_index_rea;
  assign o_index_qua = r_index_qua;
  assign o_index_cor = r_index_cor;
  assign o_wen_in    = r_wen_in;
  assign o_loaded    = r_loaded;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_pac_seq.sv
// Directed self-checking bench for pac_seq in its default (undithered) build.
module tb_pac_seq;

  localparam int PW = 32;
  localparam int PD = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ld_valid;
  logic [47:0] ld_data;
  logic        ld_ready;
  logic        run_en;
  logic [31:0] fcw;
  logic        cen;
  logic        wen;
  logic [5:0]  index_wri;
  logic [47:0] d;
  logic [5:0]  index_rea;
  logic [2:0]  index_qua;
  logic [6:0]  index_cor;
  logic        wen_in;
  logic        loaded;
  logic        busy;

  int tests = 0;
  int fails = 0;

  pac_seq #(.PHASE_W(PW), .PIPE_DEPTH(PD)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_ld_valid(ld_valid),
    .i_ld_data(ld_data), .o_ld_ready(ld_ready), .i_run_en(run_en), .i_fcw(fcw),
    .o_cen(cen), .o_wen(wen), .o_index_wri(index_wri), .o_d(d),
    .o_index_rea(index_rea), .o_index_qua(index_qua), .o_index_cor(index_cor),
    .o_wen_in(wen_in), .o_loaded(loaded), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [75:0] allOut;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start    = 1'($urandom);
      ld_valid = 1'($urandom);
      ld_data  = {16'($urandom), $urandom};
      run_en   = 1'($urandom);
      fcw      = $urandom;
      tick();
      allOut = {ld_ready, cen, wen, index_wri, d, index_rea, index_qua, index_cor, wen_in, loaded, busy};
      tests++;
      if (allOut !== 76'd0) begin
        fails++;
        $display("[TB] FAIL reset_outputs cycle=%0d got %h want 0", i, allOut);
      end
    end
    reset = 1'b0; start = 1'b0; ld_valid = 1'b0; run_en = 1'b1; fcw = 32'h0001_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({busy, wen_in} !== 2'b00) begin
        fails++;
        $display("[TB] FAIL run_unloaded cycle=%0d got busy,wen_in=%b want 00", i, {busy, wen_in});
      end
    end
    run_en = 1'b0;
  endtask

  task automatic test_full_load();
    logic [47:0] expD;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if ({ld_ready, busy, loaded} !== 3'b110) begin
      fails++;
      $display("[TB] FAIL load_enter got ready,busy,loaded=%b want 110", {ld_ready, busy, loaded});
    end
    ld_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      expD    = 48'(k) * 48'h0000_0101_0101;
      ld_data = expD;
      tick();
      tests++;
      if ({wen, cen, index_wri, d} !== {2'b11, 6'(k), expD}) begin
        fails++;
        $display("[TB] FAIL full_load_write k=%0d got wen=%b cen=%b addr=%0d d=%h want 1 1 %0d %h",
                 k, wen, cen, index_wri, d, k, expD);
      end
    end
    ld_valid = 1'b0;
    tests++;
    if ({loaded, ld_ready, busy} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL full_load_done got loaded,ready,busy=%b want 100", {loaded, ld_ready, busy});
    end
    tick();
    tests++;
    if ({wen, cen} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL full_load_after got wen,cen=%b want 00", {wen, cen});
    end
  endtask

  task automatic test_gapped_load();
    int          writes;
    logic [47:0] expD;
    start = 1'b1;
    tick();
    start  = 1'b0;
    writes = 0;
    for (int c = 0; c < 128; c++) begin
      ld_valid = (c % 2 == 0);
      expD     = 48'hA5A5_0000_0000 | 48'(writes);
      ld_data  = expD;
      tick();
      tests++;
      if (ld_valid) begin
        if ({wen, cen, index_wri, d} !== {2'b11, 6'(writes), expD}) begin
          fails++;
          $display("[TB] FAIL gapped_write n=%0d got wen=%b cen=%b addr=%0d d=%h want 1 1 %0d %h",
                   writes, wen, cen, index_wri, d, writes, expD);
        end
        writes++;
      end else if ({wen, cen} !== 2'b00) begin
        fails++;
        $display("[TB] FAIL gapped_idle c=%0d got wen,cen=%b want 00", c, {wen, cen});
      end
    end
    ld_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if ({wen, loaded, ld_ready, busy} !== 4'b0100) begin
        fails++;
        $display("[TB] FAIL gapped_extra c=%0d got wen,loaded,ready,busy=%b want 0100",
                 c, {wen, loaded, ld_ready, busy});
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_run_and_stop();
    logic [15:0] top;
    fcw    = 32'h0001_0000;
    run_en = 1'b1;
    tick();
    tests++;
    if ({busy, wen_in} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL run_enter got busy,wen_in=%b want 10", {busy, wen_in});
    end
    for (int k = 0; k <= 65536; k++) begin
      tick();
      top = 16'(k);
      tests++;
      if ({wen_in, cen, index_qua, index_rea, index_cor} !== {2'b11, top[15:13], top[12:7], top[6:0]}) begin
        fails++;
        $display("[TB] FAIL run_sample k=%0d got wen_in=%b cen=%b qua=%0d rea=%0d cor=%0d want qua=%0d rea=%0d cor=%0d",
                 k, wen_in, cen, index_qua, index_rea, index_cor, top[15:13], top[12:7], top[6:0]);
      end
    end
    run_en = 1'b0;
    tick();
    tests++;
    if ({wen_in, cen, busy} !== 3'b001) begin
      fails++;
      $display("[TB] FAIL stop_first got wen_in,cen,busy=%b want 001", {wen_in, cen, busy});
    end
    for (int i = 1; i <= PD; i++) begin
      tick();
      tests++;
      if ({busy, wen_in, cen} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL flush_busy i=%0d got busy,wen_in,cen=%b want 100", i, {busy, wen_in, cen});
      end
    end
    tick();
    tests++;
    if ({busy, wen_in} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL flush_end got busy,wen_in=%b want 00", {busy, wen_in});
    end
  endtask

  task automatic test_fcw_change();
    logic [31:0] accModel;
    logic [15:0] top;
    fcw    = 32'h0123_4567;
    run_en = 1'b1;
    tick();
    accModel = 32'd0;
    for (int s = 0; s < 8; s++) begin
      if (s == 3) fcw = 32'h7FFF_0001;
      tick();
      top = accModel[31:16];
      tests++;
      if ({wen_in, index_qua, index_rea, index_cor} !== {1'b1, top[15:13], top[12:7], top[6:0]}) begin
        fails++;
        $display("[TB] FAIL fcw_change s=%0d got qua=%0d rea=%0d cor=%0d want qua=%0d rea=%0d cor=%0d",
                 s, index_qua, index_rea, index_cor, top[15:13], top[12:7], top[6:0]);
      end
      accModel = accModel + fcw;
    end
    run_en = 1'b0;
    for (int i = 0; i < PD + 2; i++) tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fcw_drain got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    fcw    = 32'h0008_0000;
    run_en = 1'b1;
    tick();
    tick();
    tick();
    run_en = 1'b0;
    tick();
    run_en = 1'b1;
    for (int i = 1; i <= PD; i++) begin
      tick();
      tests++;
      if ({busy, wen_in} !== 2'b10) begin
        fails++;
        $display("[TB] FAIL b2b_flush i=%0d got busy,wen_in=%b want 10", i, {busy, wen_in});
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_idle got busy=%b want 0", busy);
    end
    tick();
    tests++;
    if ({busy, wen_in} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL b2b_reenter got busy,wen_in=%b want 10", {busy, wen_in});
    end
    tick();
    tests++;
    if ({wen_in, index_qua, index_rea, index_cor} !== {1'b1, 3'd0, 6'd0, 7'd0}) begin
      fails++;
      $display("[TB] FAIL b2b_phase0 got wen_in=%b qua=%0d rea=%0d cor=%0d want 1 0 0 0",
               wen_in, index_qua, index_rea, index_cor);
    end
    tick();
    tests++;
    if ({wen_in, index_qua, index_rea, index_cor} !== {1'b1, 3'd0, 6'd0, 7'd8}) begin
      fails++;
      $display("[TB] FAIL b2b_phase1 got wen_in=%b qua=%0d rea=%0d cor=%0d want 1 0 0 8",
               wen_in, index_qua, index_rea, index_cor);
    end
    run_en = 1'b0;
    for (int i = 0; i < PD + 2; i++) tick();
  endtask

  task automatic test_midload_reset();
    logic [75:0] allOut;
    logic [47:0] expD;
    start = 1'b1;
    tick();
    start    = 1'b0;
    ld_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      ld_data = 48'(k);
      tick();
    end
    reset = 1'b1;
    tick();
    allOut = {ld_ready, cen, wen, index_wri, d, index_rea, index_qua, index_cor, wen_in, loaded, busy};
    tests++;
    if (allOut !== 76'd0) begin
      fails++;
      $display("[TB] FAIL midload_reset got %h want 0", allOut);
    end
    reset    = 1'b0;
    ld_valid = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start    = 1'b0;
    ld_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      expD    = 48'hFFFF_0000_0000 + 48'(k);
      ld_data = expD;
      tick();
      tests++;
      if ({wen, index_wri, d, loaded} !== {1'b1, 6'(k), expD, (k == 63)}) begin
        fails++;
        $display("[TB] FAIL reload_write k=%0d got wen=%b addr=%0d d=%h loaded=%b want 1 %0d %h %b",
                 k, wen, index_wri, d, loaded, k, expD, (k == 63));
      end
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; run_en = 1'b0; fcw = '0;
    test_reset();
    test_full_load();
    test_gapped_load();
    test_run_and_stop();
    test_fcw_change();
    test_back_to_back();
    test_midload_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
